tick_timer: RTL
===============

// Module: tick_timer
// PURPOSE
//  Programmable countdown timer driven by the 1-cycle tick strobe from the
//  system tick generator (consumer end of the tick interface). Counts down a
//  loaded value one step per tick, reports remaining count, flags expiry.
//  Sits between tick_gen and control FSMs needing N-tick timeouts/delays.
// PARAMETERS
//  CNT_WIDTH    16  width of load value and remaining count
//  AUTO_RELOAD  0   1: on expiry reload last loaded value and keep running
// PORTS
//  clk       in   1          system clock (100 MHz)
//  reset     in   1          asynchronous, active-low reset
//  tick      in   1          1-clk strobe from tick generator, one per period
//  start     in   1          1-clk: load/restart (IDLE/DONE/RUN) or resume (PAUSE)
//  stop      in   1          1-clk: pause countdown (RUN only)
//  clear     in   1          1-clk: abort, return to IDLE
//  load_val  in   CNT_WIDTH  tick count to load on start
//  count     out  CNT_WIDTH  remaining ticks (registered)
//  running   out  1          high in RUN
//  done      out  1          high in DONE (level, until start/clear)
//  expired   out  1          1-clk pulse on expiry
// BEHAVIOUR
//  - Reset (reset==0, async): state IDLE, count=0, reload reg=0, all outputs 0.
//  - States IDLE, RUN, PAUSE, DONE. Control priority per cycle:
//    clear > start > stop > tick. Lower-priority inputs ignored that cycle.
//  - clear (any state): -> IDLE, count=0, expired=0.
//  - start in IDLE/DONE/RUN: count<=load_val, reload<=load_val, -> RUN;
//    a tick in the same cycle is not applied. start in PAUSE: -> RUN, count
//    and reload unchanged (resume, no reload).
//  - start with load_val==0 (non-PAUSE): -> DONE, expired=1 next cycle,
//    count=0; no RUN cycle.
//  - stop in RUN: -> PAUSE, count held. stop in other states: ignored.
//  - RUN, tick=1, count>1: count<=count-1 (visible 1 clk after tick).
//  - RUN, tick=1, count==1: expired=1 for exactly one clk (registered, same
//    edge count becomes 0); AUTO_RELOAD=0 -> DONE, count=0;
//    AUTO_RELOAD=1 -> stay RUN, count<=reload (count never shows 0).
//  - Ticks ignored in IDLE, PAUSE, DONE. count never wraps below 0.
//  - Latency: start->running=1 one clk; final tick->expired/done one clk.
//  - expired is 0 in every cycle not listed above; never high two clks in a
//    row except AUTO_RELOAD with reload==1 and tick every clk.
//  - Reset asserted mid-RUN: immediate IDLE/zero outputs; after release stays
//    IDLE until start.
//  - Total ticks from start to expired == load_val (tick in start cycle not
//    counted).
// TESTING
//  1 Reset then load_val=3, start, ticks every 10 clk -> count 3,2,1; expired
//    pulse 1 clk after 3rd tick; done=1, running=0, count=0.
//  2 load_val=5, start, 2 ticks, stop, 4 ticks, start, 3 ticks -> count holds
//    3 in PAUSE; expired after 3rd post-resume tick; no reload on resume.
//  3 AUTO_RELOAD=1, load_val=2, 6 ticks -> expired on ticks 2,4,6; count
//    sequence 2,1,2,1,2,1,2; running stays 1.
//  4 start and tick same clk with load_val=4 -> count=4 (tick ignored);
//    clear and start same clk -> IDLE, count=0.
//  5 start with load_val=0 -> done=1 and expired=1 one clk later, count=0,
//    running never 1.
//  6 load_val=10, 4 ticks, assert reset mid-RUN -> all outputs 0 immediately;
//    ticks after release leave count=0, state IDLE.

Source files
------------

// File: rtl/tick_timer_if.sv
`default_nettype none
// ============================================================================
//  Module   : tick_timer_if
//  Purpose  : Control/status bundle between a tick_timer and its user.
//             The master side (control FSM) issues tick/start/stop/clear and
//             load_val; the slave side (tick_timer) returns count, running,
//             done and expired.
//  Ports    : tick, start, stop, clear  - 1-clk strobes    (master -> slave)
//             load_val [CNT_WIDTH]      - value for start   (master -> slave)
//             count    [CNT_WIDTH]      - remaining ticks   (slave -> master)
//             running, done, expired    - status            (slave -> master)
//  Revision : 1.0 - initial release
// ============================================================================
interface tick_timer_if #(
   parameter int CNT_WIDTH = 16
);
   logic                 tick;
   logic                 start;
   logic                 stop;
   logic                 clear;
   logic [CNT_WIDTH-1:0] load_val;
   logic [CNT_WIDTH-1:0] count;
   logic                 running;
   logic                 done;
   logic                 expired;

   modport master (
      output tick, start, stop, clear, load_val,
      input  count, running, done, expired
   );

   modport slave (
      input  tick, start, stop, clear, load_val,
      output count, running, done, expired
   );
endinterface
`default_nettype wire

// File: rtl/tick_timer.sv
`default_nettype none
// ============================================================================
//  Module   : tick_timer
//  Purpose  : Programmable countdown timer advanced by the 1-cycle tick
//             strobe. Loads a count on start, decrements once per tick while
//             running, pulses expired and (optionally) reloads on expiry.
//  Ports    : clk    - system clock
//             rst_n  - asynchronous active-low reset
//             bus    - tick_timer_if.slave (tick/start/stop/clear/load_val in,
//                      count/running/done/expired out)
//  Params   : CNT_WIDTH   - width of load value and count; must match the
//                           CNT_WIDTH of the connected interface instance
//             AUTO_RELOAD - 1: reload last loaded value on expiry, keep running
//  Revision : 1.0 - initial release
// ============================================================================
module tick_timer #(
   parameter int CNT_WIDTH   = 16,
   parameter bit AUTO_RELOAD = 1'b0
) (
   input  wire logic   clk,
   input  wire logic   rst_n,
   tick_timer_if.slave bus
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_PAUSE = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam logic [CNT_WIDTH-1:0] C_ONE = CNT_WIDTH'(1);

   logic [1:0]           state_q,   state_d;
   logic [CNT_WIDTH-1:0] count_q,   count_d;
   logic [CNT_WIDTH-1:0] reload_q,  reload_d;
   logic                 expired_q, expired_d;

   // Next-state logic. The if/else chain encodes the control priority
   // clear > start > stop > tick, so lower-priority strobes in the same
   // cycle are simply dropped.
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      reload_d  = reload_q;
      expired_d = 1'b0;

      if (bus.clear) begin
         state_d = ST_IDLE;
         count_d = '0;
      end else if (bus.start) begin
         if (state_q == ST_PAUSE) begin
            // Resume: keep the held count and the reload value.
            state_d = ST_RUN;
         end else if (bus.load_val == '0) begin
            // Zero-length timeout expires at once without a RUN cycle.
            state_d   = ST_DONE;
            count_d   = '0;
            reload_d  = '0;
            expired_d = 1'b1;
         end else begin
            state_d  = ST_RUN;
            count_d  = bus.load_val;
            reload_d = bus.load_val;
         end
      end else if (bus.stop) begin
         if (state_q == ST_RUN) begin
            state_d = ST_PAUSE;
         end
      end else if (bus.tick && (state_q == ST_RUN)) begin
         if (count_q > C_ONE) begin
            count_d = count_q - C_ONE;
         end else begin
            // Last tick (count is never 0 in RUN; <=1 also guards wrap).
            expired_d = 1'b1;
            if (AUTO_RELOAD) begin
               count_d = reload_q;
            end else begin
               state_d = ST_DONE;
               count_d = '0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         count_q   <= '0;
         reload_q  <= '0;
         expired_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         reload_q  <= reload_d;
         expired_q <= expired_d;
      end
   end

   assign bus.count   = count_q;
   assign bus.running = (state_q == ST_RUN);
   assign bus.done    = (state_q == ST_DONE);
   assign bus.expired = expired_q;

endmodule
`default_nettype wire
